uart_tx_scheduler: RTL and testbench

Owns the single UART transmitter and shares it between two requesters: the keyboard echo path (received bytes sent back) and the time-report path (send trigger from the ASCII decoder, key 'p'/'P').
On a report trigger it snapshots the watch time and sequences the 13-byte ASCII frame "HH:MM:SS.CC\r\n" through the TX start/busy handshake.
Echo bytes are buffered in a small FIFO and interleaved only at report-frame boundaries.
It sits between the ascii2btn decoder / UART RX and the uart_tx core.

---
 rtl/uart_tx_sched_pkg.sv | 46 ++++
 rtl/bin2ascii2.sv | 19 +
 rtl/uart_tx_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_sched_pkg.sv
// Shared constants, state encoding and frame-byte helper for uart_tx_scheduler.
// Frame layout: "HH:MM:SS.CC" CR LF, byte index 0..12.
package uart_tx_sched_pkg;

  localparam logic [7:0] ZERO  = 8'h30;
  localparam logic [7:0] COLON = 8'h3A;
  localparam logic [7:0] DOT   = 8'h2E;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;

  localparam int FRAME_LEN = 13;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  function automatic logic [7:0] frame_byte(
    input logic [3:0]  idx,
    input logic [15:0] h,
    input logic [15:0] m,
    input logic [15:0] s,
    input logic [15:0] c
  );
    logic [7:0] b;
    case (idx)
      4'd0:    b = h[15:8];
      4'd1:    b = h[7:0];
      4'd2:    b = COLON;
      4'd3:    b = m[15:8];
      4'd4:    b = m[7:0];
      4'd5:    b = COLON;
      4'd6:    b = s[15:8];
      4'd7:    b = s[7:0];
      4'd8:    b = DOT;
      4'd9:    b = c[15:8];
      4'd10:   b = c[7:0];
      4'd11:   b = CR;
      default: b = LF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/bin2ascii2.sv
// Binary 0..127 to two ASCII decimal digits; values above 99 print as "99".
// Ports: i_val (7b value), o_tens / o_units (ASCII digits).
module bin2ascii2
  import uart_tx_sched_pkg::*;
(
  input  logic [6:0] i_val,
  output logic [7:0] o_tens,
  output logic [7:0] o_units
);

  logic [6:0] w_v;

  always_comb begin
    w_v     = (i_val > 7'd99) ? 7'd99 : i_val;
    o_tens  = ZERO + 8'(w_v / 7'd10);
    o_units = ZERO + 8'(w_v % 7'd10);
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART TX between echo bytes (FIFO) and atomic 13-byte time reports.
// Ports: clk/reset (async, high); i_echo_valid/i_echo_data echo input;
//   i_send_trig report request; i_hour/i_min/i_sec/i_csec watch time;
//   i_tx_busy from TX core; o_tx_start/o_tx_data to TX core;
//   o_report_busy frame in progress; o_echo_drop echo overflow pulse.
// Build option: define UART_TX_SCHED_ECHO_EN to enable the echo FIFO path.
module uart_tx_scheduler
  import uart_tx_sched_pkg::*;
#(
  parameter int ECHO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_echo_valid,
  input  logic [7:0] i_echo_data,
  input  logic       i_send_trig,
  input  logic [4:0] i_hour,
  input  logic [5:0] i_min,
  input  logic [5:0] i_sec,
  input  logic [6:0] i_csec,
  input  logic       i_tx_busy,
  output logic       o_tx_start,
  output logic [7:0] o_tx_data,
  output logic       o_report_busy,
  output logic       o_echo_drop
);

  localparam int AW = $clog2(ECHO_DEPTH);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  state_t r_state, w_state_nxt;

  logic          r_pend;
  logic          r_report_busy;
  logic          r_is_rep;
  logic [3:0]    r_idx;
  logic [7:0]    r_tx_data;
  logic [CW-1:0] r_ack_cnt;
  logic [4:0]    r_hour;
  logic [5:0]    r_min;
  logic [5:0]    r_sec;
  logic [6:0]    r_csec;

  logic       w_sel_rep;
  logic       w_sel_echo;
  logic       w_advance;
  logic       w_done;
  logic       w_empty;
  logic [7:0] w_echo_head;

  // In IDLE the first byte must come from the live time, since the
  // snapshot registers load on the same edge; afterwards use the snapshot.
  logic       w_is_idle;
  logic [6:0] w_h, w_m, w_s, w_c;
  logic [7:0] w_h1, w_h0, w_m1, w_m0;
  logic [7:0] w_s1, w_s0, w_c1, w_c0;
  logic [3:0] w_bidx;
  logic [7:0] w_fbyte;

  always_comb begin
    w_is_idle = (r_state == IDLE);
    w_h = w_is_idle ? {2'b0, i_hour} : {2'b0, r_hour};
    w_m = w_is_idle ? {1'b0, i_min}  : {1'b0, r_min};
    w_s = w_is_idle ? {1'b0, i_sec}  : {1'b0, r_sec};
    w_c = w_is_idle ? i_csec         : r_csec;
    w_bidx  = w_is_idle ? 4'd0 : r_idx + 4'd1;
    w_fbyte = frame_byte(w_bidx, {w_h1, w_h0},
                         {w_m1, w_m0}, {w_s1, w_s0},
                         {w_c1, w_c0});
  end

  bin2ascii2 u_hour (.i_val(w_h), .o_tens(w_h1), .o_units(w_h0));
  bin2ascii2 u_min  (.i_val(w_m), .o_tens(w_m1), .o_units(w_m0));
  bin2ascii2 u_sec  (.i_val(w_s), .o_tens(w_s1), .o_units(w_s0));
  bin2ascii2 u_csec (.i_val(w_c), .o_tens(w_c1), .o_units(w_c0));

  always_comb begin
    w_state_nxt = r_state;
    o_tx_start  = 1'b0;
    w_sel_rep   = 1'b0;
    w_sel_echo  = 1'b0;
    w_advance   = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_pend) begin
          w_sel_rep   = 1'b1;
          w_state_nxt = ISSUE;
        end else if (!w_empty) begin
          w_sel_echo  = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (!i_tx_busy) begin
          o_tx_start  = 1'b1;
          w_state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (i_tx_busy)
          w_state_nxt = WAIT_DONE;
        else if (r_ack_cnt == CW'(ACK_TIMEOUT - 1))
          w_state_nxt = ISSUE;
      end
      WAIT_DONE: begin
        if (!i_tx_busy) begin
          if (!r_is_rep || r_idx == 4'(FRAME_LEN - 1)) begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_advance   = 1'b1;
            w_state_nxt = ISSUE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_pend        <= 1'b0;
      r_report_busy <= 1'b0;
      r_is_rep      <= 1'b0;
      r_idx         <= 4'd0;
      r_tx_data     <= 8'd0;
      r_ack_cnt     <= '0;
      r_hour        <= '0;
      r_min         <= '0;
      r_sec         <= '0;
      r_csec        <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_sel_rep)
        r_pend <= 1'b0;
      else if (i_send_trig && !r_report_busy)
        r_pend <= 1'b1;
      if (w_sel_rep) begin
        r_hour        <= i_hour;
        r_min         <= i_min;
        r_sec         <= i_sec;
        r_csec        <= i_csec;
        r_is_rep      <= 1'b1;
        r_idx         <= 4'd0;
        r_report_busy <= 1'b1;
        r_tx_data     <= w_fbyte;
      end else if (w_sel_echo) begin
        r_is_rep  <= 1'b0;
        r_tx_data <= w_echo_head;
      end
      if (w_advance) begin
        r_idx     <= r_idx + 4'd1;
        r_tx_data <= w_fbyte;
      end
      if (w_done)
        r_report_busy <= 1'b0;
      if (r_state == WAIT_ACK && !i_tx_busy)
        r_ack_cnt <= r_ack_cnt + CW'(1);
      else
        r_ack_cnt <= '0;
    end
  end

  assign o_tx_data     = r_tx_data;
  assign o_report_busy = r_report_busy;

`ifdef UART_TX_SCHED_ECHO_EN
  logic [7:0] r_fifo [ECHO_DEPTH];
  logic [AW:0] r_wr, r_rd;
  logic        r_drop;
  logic        w_full, w_push;

  // A pop in the same cycle frees a slot, so a write to a full FIFO
  // still lands when the scheduler is taking the head.
  always_comb begin
    w_empty     = (r_wr == r_rd);
    w_full      = (r_wr[AW] != r_rd[AW]) &&
                  (r_wr[AW-1:0] == r_rd[AW-1:0]);
    w_push      = i_echo_valid && (!w_full || w_sel_echo);
    w_echo_head = r_fifo[r_rd[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_fifo[r_wr[AW-1:0]] <= i_echo_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_drop <= 1'b0;
    end else begin
      if (w_push)
        r_wr <= r_wr + (AW+1)'(1);
      if (w_sel_echo)
        r_rd <= r_rd + (AW+1)'(1);
      r_drop <= i_echo_valid && !w_push;
    end
  end

  assign o_echo_drop = r_drop;
`else
  logic w_unused_echo;
  assign w_unused_echo = ^{i_echo_valid, i_echo_data};
  assign w_empty       = 1'b1;
  assign w_echo_head   = 8'd0;
  assign o_echo_drop   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: TX core model, string-level
// frame model, monitor popping expected bytes on every o_tx_start.
module tb_uart_tx_scheduler;

  localparam int ECHO_DEPTH  = 4;
  localparam int ACK_TIMEOUT = 15;
  localparam int BUSY_LEN    = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_echo_valid;
  logic [7:0] i_echo_data;
  logic       i_send_trig;
  logic [4:0] i_hour;
  logic [5:0] i_min;
  logic [5:0] i_sec;
  logic [6:0] i_csec;
  logic       i_tx_busy;
  logic       o_tx_start;
  logic [7:0] o_tx_data;
  logic       o_report_busy;
  logic       o_echo_drop;

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .ECHO_DEPTH (ECHO_DEPTH),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_echo_valid (i_echo_valid),
    .i_echo_data  (i_echo_data),
    .i_send_trig  (i_send_trig),
    .i_hour       (i_hour),
    .i_min        (i_min),
    .i_sec        (i_sec),
    .i_csec       (i_csec),
    .i_tx_busy    (i_tx_busy),
    .o_tx_start   (o_tx_start),
    .o_tx_data    (o_tx_data),
    .o_report_busy(o_report_busy),
    .o_echo_drop  (o_echo_drop)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cnt = 0;
  int start_cyc[$];
  int drop_cnt = 0;
  logic [8:0] sb[$];
  logic [8:0] mon_e;
  bit start_seen = 0;
  bit ignore_next = 0;
  bit hold = 0;
  int tx_cnt = 0;

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every start must match the oldest expected byte.
  always @(negedge clk) begin
    if (o_echo_drop) drop_cnt++;
    if (o_tx_start) begin
      start_cnt++;
      start_cyc.push_back(cyc);
      start_seen = 1;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_start: got 0x%0h expected none",
                 o_tx_data);
      end else begin
        mon_e = sb.pop_front();
        chk("tx_byte", int'(o_tx_data), int'(mon_e[7:0]));
        if (mon_e[8])
          chk("report_busy_in_frame", int'(o_report_busy), 1);
      end
    end
  end

  // TX core model: busy rises one cycle after start, lasts BUSY_LEN cycles.
  initial forever begin
    @(posedge clk);
    #1;
    if (reset) tx_cnt = 0;
    if (start_seen) begin
      start_seen = 0;
      if (ignore_next) ignore_next = 0;
      else tx_cnt = BUSY_LEN;
    end
    i_tx_busy = hold || (tx_cnt > 0);
    if (tx_cnt > 0) tx_cnt--;
  end

  function automatic int clamp99(int v);
    return (v > 99) ? 99 : v;
  endfunction

  task automatic push_report(int h, int m, int s, int c);
    string str;
    str = $sformatf("%02d:%02d:%02d.%02d", clamp99(h), clamp99(m),
                    clamp99(s), clamp99(c));
    for (int i = 0; i < str.len(); i++)
      sb.push_back({1'b1, str[i]});
    sb.push_back({1'b1, 8'h0D});
    sb.push_back({1'b1, 8'h0A});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(int h, int m, int s, int c);
    i_hour = 5'(h);
    i_min  = 6'(m);
    i_sec  = 6'(s);
    i_csec = 7'(c);
  endtask

  task automatic trigger();
    i_send_trig = 1;
    tick();
    i_send_trig = 0;
  endtask

  task automatic echo(logic [7:0] b);
    i_echo_valid = 1;
    i_echo_data  = b;
    tick();
    i_echo_valid = 0;
  endtask

  task automatic wait_quiet(string name);
    int n = 0;
    while ((sb.size() != 0 || i_tx_busy || o_report_busy || tx_cnt != 0)
           && n < 3000) begin
      tick();
      n++;
    end
    chk({name, "_timeout"}, int'(n < 3000), 1);
    repeat (20) tick();
    chk({name, "_report_busy_low"}, int'(o_report_busy), 0);
    sb.delete();
  endtask

  task automatic wait_starts(int target, string name);
    int n = 0;
    while (start_cnt < target && n < 2000) begin
      tick();
      n++;
    end
    chk({name, "_start_timeout"}, int'(n < 2000), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, s, h, m, sc, c, n;
    logic [7:0] b;
    reset = 1;
    i_echo_valid = 0;
    i_echo_data = 0;
    i_send_trig = 0;
    i_tx_busy = 0;
    set_time(0, 0, 0, 0);
    repeat (3) tick();
    chk("reset_tx_start", int'(o_tx_start), 0);
    chk("reset_tx_data", int'(o_tx_data), 0);
    chk("reset_report_busy", int'(o_report_busy), 0);
    chk("reset_echo_drop", int'(o_echo_drop), 0);
    reset = 0;
    repeat (2) tick();

    // Basic report, latency, snapshot isolation.
    set_time(13, 5, 42, 7);
    push_report(13, 5, 42, 7);
    t0 = cyc;
    s = start_cyc.size();
    trigger();
    tick();
    set_time(23, 59, 59, 99);
    chk("report_busy_on_accept", int'(o_report_busy), 1);
    wait_starts(start_cnt + 1, "first");
    if (start_cyc.size() > s)
      chk("trigger_latency", start_cyc[s] - t0, 2);
    else
      chk("trigger_latency_missing", start_cyc.size(), s + 1);
    wait_quiet("report1");

`ifdef UART_TX_SCHED_ECHO_EN
    // Echo a, b; report arriving mid-echo is sent whole before b.
    echo(8'h61);
    sb.push_back({1'b0, 8'h61});
    echo(8'h62);
    n = 0;
    while (!i_tx_busy && n < 100) begin
      tick();
      n++;
    end
    set_time(21, 7, 3, 55);
    push_report(21, 7, 3, 55);
    trigger();
    sb.push_back({1'b0, 8'h62});
    wait_quiet("echo_report");

    // Overflow: one byte in flight, six more with TX held busy.
    hold = 1;
    tick();
    t0 = drop_cnt;
    echo(8'h78);
    sb.push_back({1'b0, 8'h78});
    repeat (2) tick();
    for (int i = 0; i < 6; i++) begin
      i_echo_valid = 1;
      i_echo_data  = 8'h41 + 8'(i);
      if (i < ECHO_DEPTH) sb.push_back({1'b0, 8'h41 + 8'(i)});
      tick();
    end
    i_echo_valid = 0;
    repeat (2) tick();
    chk("echo_drops", drop_cnt - t0, 2);
    hold = 0;
    wait_quiet("overflow");

    // Random echo bursts that fit in FIFO plus the byte in flight.
    for (int k = 0; k < 3; k++) begin
      n = $urandom_range(1, ECHO_DEPTH);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom_range(32, 126));
        sb.push_back({1'b0, b});
        echo(b);
      end
      wait_quiet("echo_rand");
    end
`else
    // Echo path absent: bytes ignored, no drop pulses.
    hold = 1;
    tick();
    t0 = drop_cnt;
    for (int i = 0; i < 6; i++) echo(8'h41 + 8'(i));
    repeat (2) tick();
    chk("echo_drops_disabled", drop_cnt - t0, 0);
    hold = 0;
    wait_quiet("echo_disabled");
`endif

    // Clamp and ignored second trigger.
    set_time(9, 30, 15, 120);
    push_report(9, 30, 15, 120);
    s = start_cnt;
    trigger();
    wait_starts(s + 3, "dbl");
    trigger();
    wait_quiet("clamp_dbl");

    // First start ignored by TX: same byte retried after timeout.
    set_time(1, 2, 3, 4);
    sb.push_back({1'b1, 8'h30});
    push_report(1, 2, 3, 4);
    ignore_next = 1;
    s = start_cyc.size();
    trigger();
    wait_quiet("retry");
    if (start_cyc.size() >= s + 2)
      chk("retry_gap", start_cyc[s+1] - start_cyc[s], ACK_TIMEOUT + 1);
    else
      chk("retry_gap_missing", start_cyc.size(), s + 2);

    // Random reports.
    for (int k = 0; k < 4; k++) begin
      h  = $urandom_range(0, 31);
      m  = $urandom_range(0, 63);
      sc = $urandom_range(0, 63);
      c  = $urandom_range(0, 127);
      set_time(h, m, sc, c);
      push_report(h, m, sc, c);
      trigger();
      wait_quiet("rand_report");
    end

    // Reset in the middle of a frame.
    set_time(12, 34, 56, 78);
    push_report(12, 34, 56, 78);
    s = start_cnt;
    trigger();
    wait_starts(s + 5, "mid_reset");
    reset = 1;
    #1;
    chk("midrst_tx_start", int'(o_tx_start), 0);
    chk("midrst_tx_data", int'(o_tx_data), 0);
    chk("midrst_report_busy", int'(o_report_busy), 0);
    chk("midrst_echo_drop", int'(o_echo_drop), 0);
    sb.delete();
    repeat (2) tick();
    reset = 0;
    s = start_cnt;
    repeat (60) tick();
    chk("no_start_after_reset", start_cnt, s);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
